// File: rtl/ppg_trig_seq_pkg.sv
// Shared definitions for the ppg_unit trigger sequencer: FSM encodings and
// default widths shared with ppg_unit.
package ppg_trig_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam int PPG_WIDTH  = 16;
  localparam int PPG_PWIDTH = 16;
  localparam int PPG_RWIDTH = 16;
  localparam int PPG_DEPTH  = 4;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ppg_trig_seq_step_table.sv
// Step table: DEPTH entries of packed {lead, hold, period}, synchronous write,
// combinational read. A write and a read of the same entry at one edge see the old value.
module ppg_trig_seq_step_table
  import ppg_trig_seq_pkg::*;
#(
  parameter int WIDTH  = PPG_WIDTH,
  parameter int PWIDTH = PPG_PWIDTH,
  parameter int DEPTH  = PPG_DEPTH,
  localparam int AW    = addr_w(DEPTH),
  localparam int EW    = 2*WIDTH + PWIDTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WIDTH-1:0]  wlead,
  input  logic [WIDTH-1:0]  whold,
  input  logic [PWIDTH-1:0] wperiod,
  input  logic [AW-1:0]     raddr,
  output logic [WIDTH-1:0]  rlead,
  output logic [WIDTH-1:0]  rhold,
  output logic [PWIDTH-1:0] rperiod
);

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] rdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && (32'(waddr) < DEPTH)) begin
      mem[waddr] <= {wlead, whold, wperiod};
    end
  end

  assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;
  assign {rlead, rhold, rperiod} = rdata;

endmodule

// File: rtl/ppg_trig_seq.sv
// Step sequencer feeding ppg_unit: plays the step table as a train of 1-cycle
// trig pulses with stable t_lead/t_hold words, repeated n_loops times (0 = forever).
module ppg_trig_seq
  import ppg_trig_seq_pkg::*;
#(
  parameter int WIDTH  = PPG_WIDTH,
  parameter int PWIDTH = PPG_PWIDTH,
  parameter int RWIDTH = PPG_RWIDTH,
  parameter int DEPTH  = PPG_DEPTH,
  localparam int AW    = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [WIDTH-1:0]  cfg_lead,
  input  logic [WIDTH-1:0]  cfg_hold,
  input  logic [PWIDTH-1:0] cfg_period,
  input  logic [AW:0]       n_steps,
  input  logic [RWIDTH-1:0] n_loops,
  output logic              trig,
  output logic [WIDTH-1:0]  t_lead,
  output logic [WIDTH-1:0]  t_hold,
  output logic [AW-1:0]     step_idx,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [AW-1:0]     step_q, step_d;
  logic [RWIDTH-1:0] loop_q, loop_d, nloops_q;
  logic [AW:0]       nsteps_q;
  logic [PWIDTH-1:0] cnt_q;
  logic              short_q;
  logic              fire_d, done_d, launch;
  logic              last_step, last_loop, period_end;
  logic [WIDTH-1:0]  rd_lead, rd_hold;
  logic [PWIDTH-1:0] rd_period;

  function automatic logic [AW:0] clamp_steps(input logic [AW:0] n);
    if (n == '0) return (AW+1)'(1);
    if (32'(n) > DEPTH) return (AW+1)'(DEPTH);
    return n;
  endfunction

  ppg_trig_seq_step_table #(
    .WIDTH  (WIDTH),
    .PWIDTH (PWIDTH),
    .DEPTH  (DEPTH)
  ) u_table (
    .clk     (clk),
    .rstn    (rstn),
    .we      (cfg_we),
    .waddr   (cfg_addr),
    .wlead   (cfg_lead),
    .whold   (cfg_hold),
    .wperiod (cfg_period),
    .raddr   (step_d),
    .rlead   (rd_lead),
    .rhold   (rd_hold),
    .rperiod (rd_period)
  );

  assign launch     = (state_q == ST_IDLE) && start && !abort;
  assign last_step  = (({1'b0, step_q} + (AW+1)'(1)) == nsteps_q);
  assign last_loop  = (nloops_q != '0) && (loop_q == (nloops_q - RWIDTH'(1)));
  // Periods of 0/1 skip WAIT entirely so trigs come back to back.
  assign period_end = ((state_q == ST_FIRE) && short_q) ||
                      ((state_q == ST_WAIT) && (cnt_q == '0));

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    loop_d  = loop_q;
    fire_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_FIRE;
          step_d  = '0;
          loop_d  = '0;
          fire_d  = 1'b1;
        end
      end
      default: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (period_end) begin
          if (last_step && last_loop) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (last_step) begin
            state_d = ST_FIRE;
            step_d  = '0;
            loop_d  = loop_q + RWIDTH'(1);
            fire_d  = 1'b1;
          end else begin
            state_d = ST_FIRE;
            step_d  = step_q + AW'(1);
            fire_d  = 1'b1;
          end
        end else if (state_q == ST_FIRE) begin
          state_d = ST_WAIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      step_q   <= '0;
      loop_q   <= '0;
      nloops_q <= '0;
      nsteps_q <= '0;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      trig     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      t_lead   <= '0;
      t_hold   <= '0;
      step_idx <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      loop_q  <= loop_d;
      trig    <= fire_d;
      busy    <= (state_d != ST_IDLE);
      done    <= done_d;
      if (launch) begin
        nsteps_q <= clamp_steps(n_steps);
        nloops_q <= n_loops;
      end
      // Counter holds the number of WAIT cycles left after the current one.
      if (fire_d) begin
        t_lead   <= rd_lead;
        t_hold   <= rd_hold;
        step_idx <= step_d;
        short_q  <= (rd_period <= PWIDTH'(1));
        cnt_q    <= (rd_period > PWIDTH'(1)) ? (rd_period - PWIDTH'(2)) : '0;
      end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - PWIDTH'(1);
      end
    end
  end

endmodule
